// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame buffer.
// fb_addr maps buffer (x, y) to a linear address with shifts and one add.
package fb_pkg;

    localparam int H_RES  = 320;
    localparam int V_RES  = 240;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 17;
    localparam int RAM_AW = ADDR_W + 1;

    typedef enum logic {
        DRAWING    = 1'b0,
        WAIT_VSYNC = 1'b1
    } fb_state_t;

    // y*320 + x == (y << 8) + (y << 6) + x
    function automatic logic [ADDR_W-1:0] fb_addr(
        input logic [8:0] x,
        input logic [8:0] y
    );
        logic [ADDR_W-1:0] yy;
        logic [ADDR_W-1:0] xx;
        yy = {8'b0, y};
        xx = {8'b0, x};
        return (yy << 8) + (yy << 6) + xx;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Written as a plain array so synthesis maps it onto block RAM.
module frame_ram #(
    parameter int AW = 18,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered frame buffer: engines fill the back page, the VGA scan
// reads the front page 2x scaled, and pages swap only on a vsync fall.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int H_RES = fb_pkg::H_RES,
    parameter int V_RES = fb_pkg::V_RES,
    parameter int PIX_W = fb_pkg::PIX_W
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [PIX_W-1:0] PIXEL_DIN,
    input  logic [8:0]       PIXEL_X,
    input  logic [8:0]       PIXEL_Y,
    input  logic             WE,
    input  logic             DRAW_DONE,
    input  logic [9:0]       DRAW_X,
    input  logic [9:0]       DRAW_Y,
    input  logic             VGA_VS,
    output logic [PIX_W-1:0] PIXEL_OUT,
    output logic             PAGE_SEL,
    output logic             FRAME_START,
    output logic             SWAP_PENDING
);

    fb_state_t state_q;
    logic page_q;
    logic frame_start_q;
    logic swap_pend_q;
    logic done_prev_q;
    logic vs_prev_q;

    logic [RAM_AW-1:0] raddr_q;
    logic [RAM_AW-1:0] raddr_d;
    logic blank_q;
    logic blank2_q;
    logic blank_d;

    logic              wr_en;
    logic [RAM_AW-1:0] waddr;
    logic [PIX_W-1:0]  rdata;
    logic              done_rise;
    logic              vs_fall;
    logic              wr_in_range;

    assign done_rise = DRAW_DONE & ~done_prev_q;
    assign vs_fall   = vs_prev_q & ~VGA_VS;

    assign wr_in_range = (PIXEL_X < 9'(H_RES)) && (PIXEL_Y < 9'(V_RES));
    assign wr_en = WE && (state_q == DRAWING) && wr_in_range;
    assign waddr = {page_q, fb_addr(PIXEL_X, PIXEL_Y)};

    // Scan is 2x the buffer; drop the LSB of each scan coordinate.
    assign blank_d = (DRAW_X >= 10'(2 * H_RES)) ||
                     (DRAW_Y >= 10'(2 * V_RES));
    assign raddr_d = {~page_q, fb_addr(DRAW_X[9:1], DRAW_Y[9:1])};

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q       <= DRAWING;
            page_q        <= 1'b1;
            frame_start_q <= 1'b0;
            swap_pend_q   <= 1'b0;
            done_prev_q   <= 1'b0;
            vs_prev_q     <= 1'b1;
            raddr_q       <= '0;
            blank_q       <= 1'b1;
            blank2_q      <= 1'b1;
        end else begin
            frame_start_q <= 1'b0;
            done_prev_q   <= DRAW_DONE;
            vs_prev_q     <= VGA_VS;
            raddr_q       <= raddr_d;
            blank_q       <= blank_d;
            blank2_q      <= blank_q;
            unique case (state_q)
                DRAWING: begin
                    if (done_rise) begin
                        state_q     <= WAIT_VSYNC;
                        swap_pend_q <= 1'b1;
                    end
                end
                WAIT_VSYNC: begin
                    if (vs_fall) begin
                        state_q       <= DRAWING;
                        page_q        <= ~page_q;
                        frame_start_q <= 1'b1;
                        swap_pend_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    frame_ram #(
        .AW(RAM_AW),
        .DW(PIX_W)
    ) u_ram (
        .clk_i  (CLOCK_50),
        .we_i   (wr_en),
        .waddr_i(waddr),
        .wdata_i(PIXEL_DIN),
        .raddr_i(raddr_q),
        .rdata_o(rdata)
    );

    assign PIXEL_OUT    = blank2_q ? '0 : rdata;
    assign PAGE_SEL     = page_q;
    assign FRAME_START  = frame_start_q;
    assign SWAP_PENDING = swap_pend_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Scoreboard bench for frame_buffer_ctrl: stimulus queues expectations
// tagged with a due cycle, a negedge monitor pops and compares them.
module tb_frame_buffer_ctrl;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] PIXEL_DIN = '0;
    logic [8:0] PIXEL_X = '0;
    logic [8:0] PIXEL_Y = '0;
    logic       WE = 1'b0;
    logic       DRAW_DONE = 1'b0;
    logic [9:0] DRAW_X = 10'd700;
    logic [9:0] DRAW_Y = '0;
    logic       VGA_VS = 1'b1;
    logic [7:0] PIXEL_OUT;
    logic       PAGE_SEL;
    logic       FRAME_START;
    logic       SWAP_PENDING;

    frame_buffer_ctrl dut (
        .CLOCK_50    (clk),
        .RESET       (RESET),
        .PIXEL_DIN   (PIXEL_DIN),
        .PIXEL_X     (PIXEL_X),
        .PIXEL_Y     (PIXEL_Y),
        .WE          (WE),
        .DRAW_DONE   (DRAW_DONE),
        .DRAW_X      (DRAW_X),
        .DRAW_Y      (DRAW_Y),
        .VGA_VS      (VGA_VS),
        .PIXEL_OUT   (PIXEL_OUT),
        .PAGE_SEL    (PAGE_SEL),
        .FRAME_START (FRAME_START),
        .SWAP_PENDING(SWAP_PENDING)
    );

    always #10 clk = ~clk;

    typedef struct {
        string      name;
        int         kind;
        logic [7:0] exp;
        int         due;
    } item_t;

    item_t sb[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 pixel, 1 page_sel, 2 frame_start, 3 swap_pending
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [7:0] act;
                case (sb[i].kind)
                    0:       act = PIXEL_OUT;
                    1:       act = {7'b0, PAGE_SEL};
                    2:       act = {7'b0, FRAME_START};
                    default: act = {7'b0, SWAP_PENDING};
                endcase
                checks++;
                if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %h expected %h",
                             sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input string nm, input int k,
                        input logic [7:0] v, input int d);
        item_t it;
        it.name = nm;
        it.kind = k;
        it.exp  = v;
        it.due  = cyc + d;
        sb.push_back(it);
    endtask

    task automatic ctl(input string nm, input logic pg,
                       input logic fs, input logic sp, input int d);
        push({nm, "_page"}, 1, {7'b0, pg}, d);
        push({nm, "_fs"},   2, {7'b0, fs}, d);
        push({nm, "_sp"},   3, {7'b0, sp}, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] x, input logic [8:0] y,
                      input logic [7:0] d);
        WE = 1'b1;
        PIXEL_X = x;
        PIXEL_Y = y;
        PIXEL_DIN = d;
        tick();
        WE = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [9:0] dx,
                      input logic [9:0] dy, input logic [7:0] v);
        DRAW_X = dx;
        DRAW_Y = dy;
        push(nm, 0, v, 2);
        tick();
        DRAW_X = 10'd700;
        DRAW_Y = '0;
    endtask

    task automatic vs_pulse(input string nm, input logic pg,
                            input logic fs, input logic sp);
        VGA_VS = 1'b0;
        ctl(nm, pg, fs, sp, 1);
        tick();
        VGA_VS = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        ctl("reset", 1'b1, 1'b0, 1'b0, 0);
        push("reset_pix", 0, 8'h00, 0);
        tick();
        RESET = 1'b0;
        tick();

        // Fill page 1 (back page after reset)
        wr(9'd5, 9'd3, 8'hA5);
        wr(9'd0, 9'd0, 8'h11);
        wr(9'd0, 9'd1, 8'h22);
        wr(9'd320, 9'd0, 8'h77);
        WE = 1'b1;
        PIXEL_X = 9'd319;
        PIXEL_Y = 9'd239;
        PIXEL_DIN = 8'h3C;
        DRAW_DONE = 1'b1;
        ctl("done1", 1'b1, 1'b0, 1'b1, 1);
        tick();
        WE = 1'b0;
        tick();
        DRAW_DONE = 1'b0;

        // Writes while waiting must be ignored
        push("wait_sp_a", 3, 8'h01, 1);
        wr(9'd0, 9'd0, 8'hFF);
        push("wait_sp_b", 3, 8'h01, 1);
        wr(9'd5, 9'd3, 8'h00);
        push("wait_sp_c", 3, 8'h01, 1);
        tick();

        VGA_VS = 1'b0;
        ctl("swap1", 1'b0, 1'b1, 1'b0, 1);
        tick();
        push("swap1_fs_off", 2, 8'h00, 1);
        tick();
        VGA_VS = 1'b1;
        tick();

        // Page 1 is now front
        rd("rd_a5", 10'd10, 10'd6, 8'hA5);
        rd("rd_3c", 10'd638, 10'd478, 8'h3C);
        rd("rd_3c_edge", 10'd639, 10'd479, 8'h3C);
        rd("rd_11", 10'd0, 10'd0, 8'h11);
        rd("rd_22", 10'd1, 10'd2, 8'h22);
        rd("blank_x", 10'd640, 10'd0, 8'h00);
        rd("blank_y", 10'd0, 10'd480, 8'h00);
        tick();

        // Vsync while drawing: no swap, front unchanged
        wr(9'd5, 9'd3, 8'h99);
        vs_pulse("vs_draw1", 1'b0, 1'b0, 1'b0);
        vs_pulse("vs_draw2", 1'b0, 1'b0, 1'b0);
        rd("rd_front", 10'd10, 10'd6, 8'hA5);
        tick();

        // DRAW_DONE held across the swap
        DRAW_DONE = 1'b1;
        push("hold_sp", 3, 8'h01, 1);
        tick();
        VGA_VS = 1'b0;
        ctl("swap2", 1'b1, 1'b1, 1'b0, 1);
        tick();
        VGA_VS = 1'b1;
        push("hold_noacc", 3, 8'h00, 1);
        tick();
        rd("rd_99", 10'd10, 10'd6, 8'h99);
        vs_pulse("hold_vs", 1'b1, 1'b0, 1'b0);
        DRAW_DONE = 1'b0;
        tick();
        DRAW_DONE = 1'b1;
        push("redone_sp", 3, 8'h01, 1);
        tick();
        DRAW_DONE = 1'b0;
        vs_pulse("swap3", 1'b0, 1'b1, 1'b0);

        // Reset while waiting for vsync
        DRAW_DONE = 1'b1;
        push("pre_rst_sp", 3, 8'h01, 1);
        tick();
        DRAW_DONE = 1'b0;
        tick();
        RESET = 1'b1;
        ctl("rst_wait", 1'b1, 1'b0, 1'b0, 1);
        push("rst_pix", 0, 8'h00, 1);
        tick();
        RESET = 1'b0;
        vs_pulse("rst_vs", 1'b1, 1'b0, 1'b0);
        rd("rst_blank", 10'd700, 10'd100, 8'h00);
        rd("rst_keep", 10'd10, 10'd6, 8'h99);

        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
